// File: rtl/bus_port_ctrl.sv
// bus_port_ctrl: tristate bus port with held, turnaround-gapped writes and a synchronised read path.
// The tristate buffer stands in for the per-pin SB_IO (simple input, simple tristate output).
module bus_port_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire  [WIDTH-1:0] bus_pack,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_change,
    output logic             bus_busy
);
    localparam int CNT_MAX = (HOLD_CYCLES > TURN_CYCLES) ? ((HOLD_CYCLES > 2) ? HOLD_CYCLES : 2)
                                                         : ((TURN_CYCLES > 2) ? TURN_CYCLES : 2);
    localparam int CW = $clog2(CNT_MAX);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TURN_LD = CW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    state_t                            state_q, state_d;
    logic [CW-1:0]                     cnt_q, cnt_d;
    logic [WIDTH-1:0]                  out_q, out_d;
    logic                              oe_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;
    logic                              rd_change_q;

    assign bus_pack  = oe_q ? out_q : {WIDTH{1'bz}};
    assign rd_data   = sync_q[SYNC_STAGES-1];
    assign rd_change = rd_change_q;
    assign wr_ready  = (state_q == IDLE);
    assign bus_busy  = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            IDLE: if (wr_valid) begin
                state_d = DRIVE;
                cnt_d   = HOLD_LD;
                out_d   = wr_data;
            end
            DRIVE: begin
                state_d = (cnt_q != '0) ? DRIVE : (TURN_CYCLES > 0) ? TURN : IDLE;
                cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : TURN_LD;
            end
            TURN: begin
                state_d = (cnt_q != '0) ? TURN : IDLE;
                cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // OE follows the registered state, so the pins are driven one edge after DRIVE is entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            oe_q        <= 1'b0;
            sync_q      <= '0;
            prev_q      <= '0;
            rd_change_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            oe_q        <= (state_q == DRIVE);
            sync_q[0]   <= bus_pack;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q      <= rd_data;
            rd_change_q <= (state_q == IDLE) && (rd_data != prev_q);
        end
    end
endmodule

// File: tb/tb_bus_port_ctrl.sv
// tb_bus_port_ctrl: directed vectors for the bus port, two parameterisations on separate buses.
module tb_bus_port_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] wr_data_a, wr_data_b, ext_a, ext_b;
    logic       wr_valid_a, wr_valid_b, ext_en_a, ext_en_b;
    logic       wr_ready_a, wr_ready_b, rd_change_a, rd_change_b, bus_busy_a, bus_busy_b;
    logic [7:0] rd_data_a, rd_data_b;
    wire  [7:0] bus_a, bus_b;
    int         n_chk = 0;
    int         n_fail = 0;

    assign bus_a = ext_en_a ? ext_a : 8'hzz;
    assign bus_b = ext_en_b ? ext_b : 8'hzz;

    always #5 clk = ~clk;

    bus_port_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .HOLD_CYCLES(3), .TURN_CYCLES(2)) u_dut_a (
        .clk(clk), .reset(reset), .bus_pack(bus_a), .wr_data(wr_data_a), .wr_valid(wr_valid_a),
        .wr_ready(wr_ready_a), .rd_data(rd_data_a), .rd_change(rd_change_a), .bus_busy(bus_busy_a));

    bus_port_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .HOLD_CYCLES(1), .TURN_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(reset), .bus_pack(bus_b), .wr_data(wr_data_b), .wr_valid(wr_valid_b),
        .wr_ready(wr_ready_b), .rd_data(rd_data_b), .rd_change(rd_change_b), .bus_busy(bus_busy_b));

    typedef struct {
        logic [7:0] pin;
        logic [7:0] exp_rd;
        logic       exp_chg;
    } rd_vec_t;

    rd_vec_t vec[13];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        vec[0]  = '{8'h3C, 8'h00, 1'b0};
        vec[1]  = '{8'h3C, 8'h3C, 1'b0};
        vec[2]  = '{8'h3C, 8'h3C, 1'b1};
        vec[3]  = '{8'h3C, 8'h3C, 1'b0};
        vec[4]  = '{8'h3C, 8'h3C, 1'b0};
        vec[5]  = '{8'h55, 8'h3C, 1'b0};
        vec[6]  = '{8'h55, 8'h55, 1'b0};
        vec[7]  = '{8'h55, 8'h55, 1'b1};
        vec[8]  = '{8'h0F, 8'h55, 1'b0};
        vec[9]  = '{8'hF0, 8'h0F, 1'b0};
        vec[10] = '{8'hF0, 8'hF0, 1'b1};
        vec[11] = '{8'hF0, 8'hF0, 1'b1};
        vec[12] = '{8'hF0, 8'hF0, 1'b0};

        reset = 1'b1;
        wr_valid_a = 1'b1; wr_data_a = 8'h77; ext_en_a = 1'b1; ext_a = 8'hFF;
        wr_valid_b = 1'b0; wr_data_b = 8'h00; ext_en_b = 1'b1; ext_b = 8'h00;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_pins_released", bus_a, 8'hFF);
            chk("reset_busy", bus_busy_a, 1'b0);
            chk("reset_rd_change", rd_change_a, 1'b0);
            chk("reset_rd_data", rd_data_a, 8'h00);
        end
        reset = 1'b0; wr_valid_a = 1'b0; ext_a = 8'h00;
        tick();
        chk("post_reset_ready", wr_ready_a, 1'b1);
        chk("post_reset_no_write", bus_busy_a, 1'b0);
        repeat (4) tick();

        for (int i = 0; i < 13; i++) begin
            ext_a = vec[i].pin;
            tick();
            chk($sformatf("vec%0d_rd_data", i), rd_data_a, vec[i].exp_rd);
            chk($sformatf("vec%0d_rd_change", i), rd_change_a, vec[i].exp_chg);
            chk($sformatf("vec%0d_ready", i), wr_ready_a, 1'b1);
        end

        ext_a = 8'hA5;
        repeat (5) tick();
        ext_en_a = 1'b0; wr_data_a = 8'hA5; wr_valid_a = 1'b1;
        tick();
        wr_valid_a = 1'b0;
        chk("single_accept", bus_busy_a, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (k <= 3) chk($sformatf("single_pins_k%0d", k), bus_a, 8'hA5);
            chk($sformatf("single_ready_k%0d", k), wr_ready_a, k >= 5);
            chk($sformatf("single_busy_k%0d", k), bus_busy_a, k < 5);
            chk($sformatf("single_no_rdchg_k%0d", k), rd_change_a, 1'b0);
            if (k == 4) begin
                ext_a = 8'hA5; ext_en_a = 1'b1;
            end
        end

        ext_en_a = 1'b0; wr_data_a = 8'h01; wr_valid_a = 1'b1;
        tick();
        wr_data_a = 8'h02;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k <= 3) chk($sformatf("b2b_first_pins_k%0d", k), bus_a, 8'h01);
            if (k >= 7 && k <= 9) chk($sformatf("b2b_second_pins_k%0d", k), bus_a, 8'h02);
            if (k == 4) begin
                ext_a = 8'h80; ext_en_a = 1'b1;
                #1;
            end
            if (k >= 4 && k <= 6) chk($sformatf("b2b_gap_released_k%0d", k), bus_a, 8'h80);
            chk($sformatf("b2b_ready_k%0d", k), wr_ready_a, (k == 5) || (k == 11));
            chk($sformatf("b2b_busy_k%0d", k), bus_busy_a, !((k == 5) || (k == 11)));
            if (k == 6) begin
                ext_en_a = 1'b0; wr_valid_a = 1'b0;
            end
            if (k == 10) begin
                ext_a = 8'h02; ext_en_a = 1'b1;
            end
        end

        ext_en_a = 1'b0; wr_data_a = 8'hE7; wr_valid_a = 1'b1;
        tick();
        wr_valid_a = 1'b0;
        tick();
        chk("mid_drive1_pins", bus_a, 8'hE7);
        tick();
        chk("mid_drive2_pins", bus_a, 8'hE7);
        reset = 1'b1;
        tick();
        chk("mid_reset_busy", bus_busy_a, 1'b0);
        chk("mid_reset_ready", wr_ready_a, 1'b1);
        ext_a = 8'h3C; ext_en_a = 1'b1;
        #1;
        chk("mid_reset_released", bus_a, 8'h3C);
        reset = 1'b0;
        tick();
        chk("mid_after_ready", wr_ready_a, 1'b1);
        chk("mid_after_busy", bus_busy_a, 1'b0);

        ext_en_b = 1'b0; wr_data_b = 8'hC3; wr_valid_b = 1'b1;
        tick();
        wr_valid_b = 1'b0;
        chk("t0_accept_ready", wr_ready_b, 1'b0);
        chk("t0_accept_busy", bus_busy_b, 1'b1);
        tick();
        chk("t0_ready_back", wr_ready_b, 1'b1);
        chk("t0_busy_back", bus_busy_b, 1'b0);
        chk("t0_pins", bus_b, 8'hC3);
        tick();
        ext_b = 8'h11; ext_en_b = 1'b1;
        #1;
        chk("t0_released", bus_b, 8'h11);
        chk("t0_still_ready", wr_ready_b, 1'b1);
        tick();
        tick();
        chk("t0_rd_data", rd_data_b, 8'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
